// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : unit-select codes, sequencer FSM states and the shared opcode type
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef logic [1:0] alu_fun_t;

  typedef enum logic [1:0] {
    UNIT_ARITH = 2'b00,
    UNIT_LOGIC = 2'b01,
    UNIT_CMP   = 2'b10,
    UNIT_SHIFT = 2'b11
  } unit_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    HOLD    = 2'b11
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// ============================================================================
// alu_cmd_fifo : command buffer, full/empty from extra-bit pointer compare
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_cmd_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Same index with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// alu_cmd_sequencer : buffers ALU commands, issues each to one unit, returns result
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [IN_WIDTH-1:0]  cmd_A,
  input  logic [IN_WIDTH-1:0]  cmd_B,
  input  logic [3:0]           cmd_FUN,
  output logic [IN_WIDTH-1:0]  A,
  output logic [IN_WIDTH-1:0]  B,
  output alu_fun_t             ALU_FUN,
  output logic                 Arith_Enable,
  output logic                 Logic_Enable,
  output logic                 CMP_Enable,
  output logic                 Shift_Enable,
  input  logic [OUT_WIDTH-1:0] ARITH_OUT,
  input  logic [OUT_WIDTH-1:0] LOGIC_OUT,
  input  logic [OUT_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_WIDTH-1:0] SHIFT_OUT,
  input  logic                 ARITH_Flag,
  input  logic                 LOGIC_Flag,
  input  logic                 CMP_Flag,
  input  logic                 SHIFT_Flag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [OUT_WIDTH-1:0] res_data,
  output logic [1:0]           res_unit,
  output logic                 res_err
);

  localparam int CMD_W = 2 * IN_WIDTH + 4;

  state_e               state;
  state_e               state_nxt;
  logic [IN_WIDTH-1:0]  a_q;
  logic [IN_WIDTH-1:0]  b_q;
  logic [3:0]           fun_q;
  unit_e                sel;
  logic                 init_done;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [CMD_W-1:0]     head;
  logic [OUT_WIDTH-1:0] sel_out;
  logic                 sel_flag;
  logic                 issue;

  // init_done keeps cmd_ready low until the first edge after reset release.
  assign cmd_ready = init_done & ~fifo_full;
  assign push      = cmd_valid & cmd_ready;

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (RST),
    .push  (push),
    .wdata ({cmd_FUN, cmd_A, cmd_B}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = HOLD;
      HOLD: begin
        if (res_ready) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      fun_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (pop) begin
      {fun_q, a_q, b_q} <= head;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign ALU_FUN = fun_q[1:0];
  assign sel     = unit_e'(fun_q[3:2]);
  assign issue   = (state == ISSUE);

  // Enables decode from state, so an async reset drops them at once.
  assign Arith_Enable = issue && (sel == UNIT_ARITH);
  assign Logic_Enable = issue && (sel == UNIT_LOGIC);
  assign CMP_Enable   = issue && (sel == UNIT_CMP);
  assign Shift_Enable = issue && (sel == UNIT_SHIFT);

  always_comb begin
    sel_out  = ARITH_OUT;
    sel_flag = ARITH_Flag;
    case (sel)
      UNIT_ARITH: begin sel_out = ARITH_OUT; sel_flag = ARITH_Flag; end
      UNIT_LOGIC: begin sel_out = LOGIC_OUT; sel_flag = LOGIC_Flag; end
      UNIT_CMP:   begin sel_out = CMP_OUT;   sel_flag = CMP_Flag;   end
      UNIT_SHIFT: begin sel_out = SHIFT_OUT; sel_flag = SHIFT_Flag; end
      default:    begin sel_out = ARITH_OUT; sel_flag = ARITH_Flag; end
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_unit  <= '0;
      res_err   <= 1'b0;
    end else if (state == CAPTURE) begin
      res_valid <= 1'b1;
      res_data  <= sel_out;
      res_unit  <= fun_q[3:2];
      res_err   <= ~sel_flag;
    end else if ((state == HOLD) && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// tb_alu_cmd_sequencer : directed and random checks against a command-stream model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_A = '0;
  logic [7:0]  cmd_B = '0;
  logic [3:0]  cmd_FUN = '0;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [1:0]  ALU_FUN;
  logic        Arith_Enable, Logic_Enable, CMP_Enable, Shift_Enable;
  logic [15:0] uout [4];
  logic [3:0]  uflag;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [1:0]  res_unit;
  logic        res_err;
  logic [3:0]  en;

  typedef struct packed { logic [3:0] fun; logic [7:0] a; logic [7:0] b; } cmd_t;
  typedef struct packed { logic [15:0] data; logic [1:0] unit; logic err; } res_t;

  cmd_t pend [$];
  res_t expq [$];
  cmd_t mon_c;
  res_t mon_r;
  logic [3:0] mon_want;
  logic prev_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_res = 0;
  bit   rand_done = 1'b0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.IN_WIDTH(8), .OUT_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_FUN(cmd_FUN),
    .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .Shift_Enable(Shift_Enable),
    .ARITH_OUT(uout[0]), .LOGIC_OUT(uout[1]), .CMP_OUT(uout[2]), .SHIFT_OUT(uout[3]),
    .ARITH_Flag(uflag[0]), .LOGIC_Flag(uflag[1]), .CMP_Flag(uflag[2]), .SHIFT_Flag(uflag[3]),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_unit(res_unit), .res_err(res_err)
  );

  assign en = {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

  // Functional-unit behaviour: shift 00=A>>1, 01=A<<1, 10=B>>1, 11=B<<1.
  function automatic logic [15:0] unit_calc(input logic [1:0] u, input logic [1:0] op,
                                            input logic [7:0] a, input logic [7:0] b);
    logic [15:0] x;
    logic [15:0] y;
    x = {8'h00, a};
    y = {8'h00, b};
    case (u)
      2'd0: case (op)
              2'd0: return x + y;
              2'd1: return x - y;
              2'd2: return x * y;
              default: return (b == 8'd0) ? 16'hFFFF : x / y;
            endcase
      2'd1: case (op)
              2'd0: return x & y;
              2'd1: return x | y;
              2'd2: return x ^ y;
              default: return {8'hA5, ~(a & b)};
            endcase
      2'd2: case (op)
              2'd0: return (a == b) ? 16'd1 : 16'd0;
              2'd1: return (a > b) ? 16'd2 : 16'd0;
              2'd2: return (a < b) ? 16'd3 : 16'd0;
              default: return 16'h8000 | x;
            endcase
      default: case (op)
              2'd0: return x >> 1;
              2'd1: return x << 1;
              2'd2: return y >> 1;
              default: return y << 1;
            endcase
    endcase
  endfunction

  // Units refuse (Flag=0) any operand A whose top three bits are all ones.
  function automatic logic flag_ok(input logic [7:0] a);
    return a[7:5] != 3'b111;
  endfunction

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) uout[i] <= 16'(i + 1) * 16'h1111;
      uflag <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (en[i]) begin
          uout[i]  <= unit_calc(2'(i), ALU_FUN, A, B);
          uflag[i] <= flag_ok(A);
        end else begin
          uflag[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Command stream model: accepted commands are issued and answered strictly in order.
  always @(negedge clk) begin
    if (RST) begin
      pend.delete();
      expq.delete();
      prev_en = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) pend.push_back('{fun: cmd_FUN, a: cmd_A, b: cmd_B});
      if (|en) begin
        check("en_onehot", $countones(en), 1);
        check("en_not_adjacent", prev_en, 0);
        if (pend.size() == 0) begin
          check("issue_without_cmd", 1, 0);
        end else begin
          mon_c    = pend.pop_front();
          mon_want = 4'b0001 << mon_c.fun[3:2];
          check("issue_enable", en, mon_want);
          check("issue_fun", ALU_FUN, mon_c.fun[1:0]);
          check("issue_a", A, mon_c.a);
          check("issue_b", B, mon_c.b);
          expq.push_back('{data: unit_calc(mon_c.fun[3:2], mon_c.fun[1:0], mon_c.a, mon_c.b),
                           unit: mon_c.fun[3:2], err: ~flag_ok(mon_c.a)});
        end
      end
      prev_en = |en;
      if (res_valid && res_ready) begin
        n_res++;
        if (expq.size() == 0) begin
          check("result_without_issue", 1, 0);
        end else begin
          mon_r = expq.pop_front();
          check("res_data", res_data, mon_r.data);
          check("res_unit", res_unit, mon_r.unit);
          check("res_err", res_err, mon_r.err);
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_A     = a;
    cmd_B     = b;
    cmd_FUN   = f;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!res_valid) check(tag, 0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((pend.size() != 0 || expq.size() != 0 || res_valid) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("drain_left", pend.size() + expq.size() + int'(res_valid), 0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #1;
    check("rst_enables", en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    RST = 1'b0;
    #1;
    check("ready_low_at_release", cmd_ready, 0);
    @(posedge clk); #1;
    check("ready_one_cycle_after", cmd_ready, 1);
  endtask

  initial begin
    int lat;
    int gap;
    int base;

    #1 RST = 1'b1;
    #2;
    check("reset_A", A, 0);
    check("reset_res_data", res_data, 0);
    check("reset_fun", ALU_FUN, 0);
    pulse_reset();

    // Shift path and accept-to-valid latency
    res_ready = 1'b1;
    send(8'd40, 8'd30, 4'b1100);
    lat = 0;
    while (!res_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency", lat, 3);
    check("shift_data", res_data, 20);
    check("shift_unit", res_unit, 3);
    check("shift_err", res_err, 0);
    tick(3);

    // Back-to-back spacing
    send(8'd50, 8'h12, 4'b1101);
    send(8'h33, 8'd5, 4'b1111);
    wait_valid("b2b_first_timeout");
    check("b2b_first", res_data, 100);
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (!res_valid && gap < 20);
    check("b2b_spacing", gap, 3);
    check("b2b_second", res_data, 10);
    tick(3);

    // Flag error, then a clean command proves the FSM moves on
    send(8'hE3, 8'h05, 4'b0000);
    wait_valid("err_timeout");
    check("err_flag", res_err, 1);
    check("err_data", res_data, 16'h00E8);
    tick(2);
    send(8'h10, 8'h20, 4'b0110);
    wait_valid("after_err_timeout");
    check("after_err_flag", res_err, 0);
    check("after_err_data", res_data, 16'h0030);
    tick(2);

    // One command per unit
    for (int u = 0; u < 4; u++) begin
      send(8'($urandom_range(0, 200)), 8'($urandom_range(1, 255)), {2'(u), 2'($urandom_range(0, 3))});
      wait_valid("decode_timeout");
      check("decode_unit", res_unit, u);
      tick(2);
    end

    // Backpressure: one held result plus a full FIFO
    res_ready = 1'b0;
    base = n_res;
    for (int i = 0; i < 5; i++) send(8'(i * 7 + 3), 8'(i + 1), 4'(i * 5));
    check("bp_ready_low", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_A = 8'hAA; cmd_B = 8'h55; cmd_FUN = 4'b0100;
    tick(4);
    cmd_valid = 1'b0;
    check("bp_still_full", cmd_ready, 0);
    check("bp_hold_valid", res_valid, 1);
    res_ready = 1'b1;
    wait_drain();
    check("bp_result_count", n_res - base, 5);

    // Reset while holding a result with three commands queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(i + 9), 8'(i + 2), 4'(i * 3));
    wait_valid("rst_hold_timeout");
    @(posedge clk); #1;
    pulse_reset();
    res_ready = 1'b1;
    tick(6);
    check("flushed_no_result", res_valid, 0);

    // Reset while an enable is high
    send(8'd1, 8'd2, 4'b1000);
    gap = 0;
    while (!(|en) && gap < 20) begin @(posedge clk); #1; gap++; end
    check("enable_seen", |en, 1);
    pulse_reset();
    tick(4);
    check("flushed_after_issue", res_valid, 0);

    // Random traffic with random consumer stalls
    base = n_res;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          tick($urandom_range(0, 2));
          send(8'($urandom), 8'($urandom), 4'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    wait_drain();
    check("rand_result_count", n_res - base, 60);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
